bus_master_port: RTL and testbench
==================================

// Module: bus_master_port
// PURPOSE
//  Initiator end of the shared 8-bit system bus (BUS_ADDR/BUS_DATA/BUS_WE, raise/ack interrupts).
//  Turns single-outstanding host requests (valid/ready) into timed bus write/read cycles.
//  Returns read data from memory-mapped responders such as the seven-segment and LED peripherals.
//  Collects per-peripheral interrupt raises and issues the matching one-cycle acks.
// PARAMETERS
//  NUM_IRQ       2      number of interrupt lines (raise/ack pairs)
//  READ_LATENCY  2      edges from address launch to BUS_DATA sample; responders register data
//  IDLE_ADDR     8'hFF  address driven when no transaction is active; must not map to any responder
// PORTS
//  CLK                  in     1        system clock, all logic on posedge
//  RESET                in     1        asynchronous, active-low (0 = reset)
//  BUS_ADDR             out    8        bus address
//  BUS_DATA             inout  8        bus data; driven only during WRITE, else 8'hZZ
//  BUS_WE               out    1        1 = write cycle
//  BUS_INTERRUPTS_RAISE in     NUM_IRQ  level raise per peripheral
//  BUS_INTERRUPTS_ACK   out    NUM_IRQ  one-cycle ack pulse per peripheral
//  req_valid            in     1        host request present
//  req_ready            out    1        1 iff state==IDLE (combinational)
//  req_we               in     1        1 = write, 0 = read
//  req_addr             in     8        target address
//  req_wdata            in     8        write data
//  resp_valid           out    1        one-cycle pulse: transaction complete (no backpressure)
//  resp_is_read         out    1        qualifies resp_rdata
//  resp_rdata           out    8        sampled read data, held until next read response
//  irq_pending          out    1        any pending interrupt
//  irq_id               out    $clog2(NUM_IRQ) lowest-index pending line (0 when none)
//  irq_ack              in     1        host consumes irq_id
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, BUS_ADDR=IDLE_ADDR, BUS_WE=0, BUS_DATA=Z,
//   resp_valid=0, resp_is_read=0, resp_rdata=0, pending=0, holdoff=0, BUS_INTERRUPTS_ACK=0.
//   Reset mid-transaction aborts it; no response is ever issued for the aborted request.
//  FSM IDLE -> WRITE | READ -> IDLE. Accept = req_valid & req_ready at edge E0; latch addr/data/we.
//  IDLE: BUS_ADDR=IDLE_ADDR, BUS_WE=0, BUS_DATA=Z.
//  WRITE (cycle E0..E1): BUS_ADDR=addr, BUS_DATA=wdata, BUS_WE=1; at E1 -> IDLE,
//   resp_valid=1, resp_is_read=0.
//  READ: BUS_ADDR=addr, BUS_WE=0, BUS_DATA=Z, counter loaded READ_LATENCY-1. At edge E0+READ_LATENCY:
//   resp_rdata<=BUS_DATA, resp_valid=1, resp_is_read=1, -> IDLE.
//  Turnaround: at least one IDLE cycle between transactions, so a responder still driving
//   after a read has released BUS_DATA before any write drives it.
//   Throughput: write 2 cycles, read READ_LATENCY+1 cycles.
//  Unmapped read: BUS_DATA floats; sampled value is undefined (X in sim). This is not an error.
//  Interrupts: pending[i] <= pending[i] | (RAISE[i] & ~holdoff[i]). Priority: lowest index.
//   On irq_ack & irq_pending: ACK[irq_id]=1 for exactly the next cycle, pending[irq_id] cleared,
//   holdoff[irq_id] set for 2 cycles so the responder can drop RAISE.
//   irq_ack with nothing pending is ignored.
//   Raise on line j while line i is being acked: latched normally.
//  Bus transactions and interrupt handling are independent and run concurrently.
// STRUCTURE
//  Shared package bus_pkg: FSM state encoding, BUS_WIDTH=8, IDLE_ADDR default,
//   peripheral base addresses (7-seg D0, etc.).
//  Sub-module irq_arbiter: pending/holdoff registers, priority encoder, ack pulse generation.
//  FSM, counter and tristate stay in the top module.
// TESTING
//  Responder model: registered read data (2-edge latency), base D0, 2 registers.
//  Reset values: RESET=0 mid-read -> immediately BUS_ADDR=FF, BUS_WE=0, BUS_DATA=Z;
//   no resp_valid after release.
//  Write D1<=8'h3C -> one cycle ADDR=D1, DATA=3C, WE=1; resp_valid 1 edge later;
//   model reg1==3C; ready low exactly 1 cycle.
//  Read D1 after the write -> resp_valid at E0+2, resp_rdata=3C, resp_is_read=1;
//   BUS_DATA never driven by master.
//  Back-to-back read D0 then write D0<=8'hA5 with req_valid held -> one IDLE cycle between;
//   no bus contention (no X on BUS_DATA during WRITE); final reg0=A5.
//  RAISE=2'b11 -> irq_id=0; ack -> ACK=2'b01 for one cycle; irq_id=1;
//   ack -> ACK=2'b10; RAISE dropped 1 cycle later -> irq_pending=0, no re-latch.
//  irq_ack with pending=0 -> ACK stays 0; read to unmapped 8'h40 -> resp_valid still at E0+2.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the 8-bit system bus master: widths, FSM encoding,
// default idle address and responder base addresses.
package bus_pkg;

    localparam int BUS_WIDTH = 8;

    // Address parked on the bus between transactions; no responder decodes it.
    localparam logic [BUS_WIDTH-1:0] IDLE_ADDR_DFLT = 8'hFF;

    // Memory-mapped responder base addresses.
    localparam logic [BUS_WIDTH-1:0] SEG7_BASE = 8'hD0;
    localparam logic [BUS_WIDTH-1:0] LED_BASE  = 8'hC0;

    // Transaction FSM encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    // Width of an interrupt index; kept at least one bit for a single line.
    function automatic int irq_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_master_port_if.sv
// Host-side request/response and interrupt-consume signals of the bus master.
// The host drives requests through the master modport; the port answers
// through the slave modport.
interface bus_master_port_if
    import bus_pkg::*;
#(
    parameter int NUM_IRQ = 2
);
    logic                               req_valid;
    logic                               req_ready;
    logic                               req_we;
    logic [BUS_WIDTH-1:0]               req_addr;
    logic [BUS_WIDTH-1:0]               req_wdata;
    logic                               resp_valid;
    logic                               resp_is_read;
    logic [BUS_WIDTH-1:0]               resp_rdata;
    logic                               irq_pending;
    logic [irq_id_width(NUM_IRQ)-1:0]   irq_id;
    logic                               irq_ack;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, irq_ack,
        input  req_ready, resp_valid, resp_is_read, resp_rdata, irq_pending, irq_id
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, irq_ack,
        output req_ready, resp_valid, resp_is_read, resp_rdata, irq_pending, irq_id
    );
endinterface

// File: rtl/irq_arbiter.sv
// Interrupt collection: latches per-line raises, picks the lowest pending
// index, and on a host ack pulses the matching bus ack for one cycle while
// masking that line for two cycles so its responder can drop the raise.
module irq_arbiter #(
    parameter int NUM_IRQ = 2,
    parameter int ID_W    = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_IRQ-1:0] raise,
    input  logic               ack_req,
    output logic [NUM_IRQ-1:0] bus_ack,
    output logic               irq_pending,
    output logic [ID_W-1:0]    irq_id
);
    logic [NUM_IRQ-1:0] pending_reg;
    logic [NUM_IRQ-1:0] ack_reg;
    logic [NUM_IRQ-1:0] clear;
    logic [1:0]         hold_cnt_reg [NUM_IRQ];

    // Lowest pending index wins; index 0 when nothing is pending.
    always_comb begin
        irq_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_reg[i]) irq_id = ID_W'(i);
        end
    end

    // One-hot line being consumed this cycle; an ack with nothing pending does nothing.
    always_comb begin
        clear = '0;
        if (ack_req && (|pending_reg)) clear[irq_id] = 1'b1;
    end

    // Pending latch, holdoff countdown and registered ack pulse per line.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pending_reg <= '0;
            ack_reg     <= '0;
            for (int i = 0; i < NUM_IRQ; i++) hold_cnt_reg[i] <= 2'd0;
        end else begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                pending_reg[i] <= (pending_reg[i] | (raise[i] & (hold_cnt_reg[i] == 2'd0)))
                                  & ~clear[i];
                ack_reg[i]     <= clear[i];
                if (clear[i])
                    hold_cnt_reg[i] <= 2'd2;
                else if (hold_cnt_reg[i] != 2'd0)
                    hold_cnt_reg[i] <= hold_cnt_reg[i] - 2'd1;
            end
        end
    end

    assign bus_ack     = ack_reg;
    assign irq_pending = |pending_reg;
endmodule

// File: rtl/bus_master_port.sv
// Initiator end of the shared 8-bit system bus. Converts single-outstanding
// host requests into timed write/read cycles and forwards interrupt handling
// to the arbiter, which runs independently of bus traffic.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int                   NUM_IRQ      = 2,
    parameter int                   READ_LATENCY = 2,
    parameter logic [BUS_WIDTH-1:0] IDLE_ADDR    = IDLE_ADDR_DFLT
) (
    input  logic                 CLK,
    input  logic                 RESET,
    output logic [BUS_WIDTH-1:0] BUS_ADDR,
    inout  wire  [BUS_WIDTH-1:0] BUS_DATA,
    output logic                 BUS_WE,
    input  logic [NUM_IRQ-1:0]   BUS_INTERRUPTS_RAISE,
    output logic [NUM_IRQ-1:0]   BUS_INTERRUPTS_ACK,
    bus_master_port_if.slave     host
);
    localparam int ID_W = irq_id_width(NUM_IRQ);

    logic [1:0]           state_reg;
    logic [BUS_WIDTH-1:0] addr_reg;
    logic [BUS_WIDTH-1:0] wdata_reg;
    logic [7:0]           cnt_reg;
    logic                 resp_valid_reg;
    logic                 resp_is_read_reg;
    logic [BUS_WIDTH-1:0] resp_rdata_reg;

    // Transaction FSM: accept in IDLE, one WRITE cycle or a counted READ, then
    // always back through IDLE so a responder finishing a read releases the bus.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg        <= ST_IDLE;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            cnt_reg          <= '0;
            resp_valid_reg   <= 1'b0;
            resp_is_read_reg <= 1'b0;
            resp_rdata_reg   <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (host.req_valid) begin
                        addr_reg  <= host.req_addr;
                        wdata_reg <= host.req_wdata;
                        cnt_reg   <= 8'(READ_LATENCY - 1);
                        state_reg <= host.req_we ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    resp_valid_reg   <= 1'b1;
                    resp_is_read_reg <= 1'b0;
                    state_reg        <= ST_IDLE;
                end
                ST_READ: begin
                    if (cnt_reg == 8'd0) begin
                        resp_rdata_reg   <= BUS_DATA;
                        resp_valid_reg   <= 1'b1;
                        resp_is_read_reg <= 1'b1;
                        state_reg        <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Bus drive follows state directly so an async reset parks the bus at once.
    assign BUS_ADDR = (state_reg == ST_IDLE) ? IDLE_ADDR : addr_reg;
    assign BUS_WE   = (state_reg == ST_WRITE);
    assign BUS_DATA = (state_reg == ST_WRITE) ? wdata_reg : {BUS_WIDTH{1'bz}};

    assign host.req_ready    = (state_reg == ST_IDLE);
    assign host.resp_valid   = resp_valid_reg;
    assign host.resp_is_read = resp_is_read_reg;
    assign host.resp_rdata   = resp_rdata_reg;

    irq_arbiter #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_irq_arbiter (
        .CLK         (CLK),
        .RESET       (RESET),
        .raise       (BUS_INTERRUPTS_RAISE),
        .ack_req     (host.irq_ack),
        .bus_ack     (BUS_INTERRUPTS_ACK),
        .irq_pending (host.irq_pending),
        .irq_id      (host.irq_id)
    );
endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: directed and random host transactions against a
// two-register responder at D0/D1, responses checked by a scoreboard monitor,
// followed by the interrupt raise/ack sequence.
module tb_bus_master_port;
    localparam int RL = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] bus_addr;
    wire  [7:0] bus_data;
    logic       bus_we;
    logic [1:0] irq_src = 2'b00;
    logic [1:0] raise_set = 2'b00;
    logic [1:0] bus_ack;
    int         cyc = 0;

    bus_master_port_if #(.NUM_IRQ(2)) host_if ();

    bus_master_port #(.NUM_IRQ(2), .READ_LATENCY(RL), .IDLE_ADDR(8'hFF)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .BUS_ADDR             (bus_addr),
        .BUS_DATA             (bus_data),
        .BUS_WE               (bus_we),
        .BUS_INTERRUPTS_RAISE (irq_src),
        .BUS_INTERRUPTS_ACK   (bus_ack),
        .host                 (host_if)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Responder: two registers at D0/D1, read data registered (2-edge latency).
    logic [7:0] regs [2] = '{8'h00, 8'h00};
    logic       rsp_drive = 1'b0;
    logic [7:0] rsp_q = 8'h00;
    wire        mapped = (bus_addr[7:1] == 7'h68);
    always @(posedge CLK) begin
        if (bus_we && mapped) regs[bus_addr[0]] <= bus_data;
        rsp_drive <= !bus_we && mapped;
        rsp_q     <= regs[bus_addr[0]];
    end
    assign bus_data = rsp_drive ? rsp_q : 8'hzz;

    // Interrupt sources: raise on request, drop on the edge after seeing its ack.
    always @(posedge CLK) irq_src <= (irq_src | raise_set) & ~bus_ack;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         cyc;
        bit         is_read;
        bit         chk;
        logic [7:0] data;
    } exp_t;
    exp_t sb [$];

    // Reference contents of the responder registers, updated at request time.
    logic [7:0] model_mem [2] = '{8'h00, 8'h00};

    // Monitor: pop and compare on every response; watch for bus contention.
    always @(negedge CLK) begin
        if (RESET) begin
            if (host_if.resp_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got resp_valid at cycle %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_cycle", cyc, e.cyc);
                    check("resp_is_read", {31'd0, host_if.resp_is_read}, {31'd0, e.is_read});
                    if (e.chk) check("resp_rdata", {24'd0, host_if.resp_rdata}, {24'd0, e.data});
                end
            end
            if (bus_we) check("no_contention", {31'd0, rsp_drive}, 32'd0);
        end
    end

    // Issue one request; returns the post-edge cycle of acceptance (-1 on timeout).
    task automatic issue(input bit we, input logic [7:0] a, input logic [7:0] d,
                         input bit push, output int acc);
        int n = 0;
        host_if.req_valid = 1'b1;
        host_if.req_we    = we;
        host_if.req_addr  = a;
        host_if.req_wdata = d;
        acc = -1;
        while (acc < 0) begin
            @(negedge CLK);
            if (host_if.req_ready) begin
                @(posedge CLK);
                #1;
                acc = cyc;
            end else if (++n > 50) begin
                check("accept_timeout", 32'd0, 32'd1);
                return;
            end
        end
        check("busy_after_accept", {31'd0, host_if.req_ready}, 32'd0);
        check("bus_addr_active", {24'd0, bus_addr}, {24'd0, a});
        check("bus_we_active", {31'd0, bus_we}, {31'd0, we});
        if (we) check("bus_wdata", {24'd0, bus_data}, {24'd0, d});
        if (push) begin
            exp_t e;
            e.cyc     = we ? acc + 1 : acc + RL;
            e.is_read = !we;
            e.chk     = !we && (a[7:1] == 7'h68);
            e.data    = model_mem[a[0]];
            sb.push_back(e);
            if (we && (a[7:1] == 7'h68)) model_mem[a[0]] = d;
        end
    endtask

    task automatic idle(input int n);
        host_if.req_valid = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic irq_ack_pulse();
        host_if.irq_ack = 1'b1;
        @(posedge CLK);
        #1;
        host_if.irq_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2;
        host_if.req_valid = 1'b0;
        host_if.req_we    = 1'b0;
        host_if.req_addr  = 8'h00;
        host_if.req_wdata = 8'h00;
        host_if.irq_ack   = 1'b0;

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        check("rst_bus_addr", {24'd0, bus_addr}, 32'hFF);
        check("rst_bus_we", {31'd0, bus_we}, 32'd0);
        check("rst_ready", {31'd0, host_if.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, host_if.resp_valid}, 32'd0);
        check("rst_resp_is_read", {31'd0, host_if.resp_is_read}, 32'd0);
        check("rst_resp_rdata", {24'd0, host_if.resp_rdata}, 32'd0);
        check("rst_irq_pending", {31'd0, host_if.irq_pending}, 32'd0);
        check("rst_bus_ack", {30'd0, bus_ack}, 32'd0);
        RESET = 1'b1;
        idle(2);

        // Reset mid-read aborts with no response
        issue(1'b0, 8'hD0, 8'h00, 1'b0, a1);
        host_if.req_valid = 1'b0;
        @(negedge CLK);
        #2;
        check("midread_addr", {24'd0, bus_addr}, 32'hD0);
        RESET = 1'b0;
        #1;
        check("abort_bus_addr", {24'd0, bus_addr}, 32'hFF);
        check("abort_bus_we", {31'd0, bus_we}, 32'd0);
        check("abort_ready", {31'd0, host_if.req_ready}, 32'd1);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        idle(6);

        // Write D1 <= 3C; ready low exactly one cycle
        issue(1'b1, 8'hD1, 8'h3C, 1'b1, a1);
        host_if.req_valid = 1'b0;
        @(posedge CLK);
        #1;
        check("ready_back_after_write", {31'd0, host_if.req_ready}, 32'd1);
        idle(1);
        check("resp_reg1", {24'd0, regs[1]}, 32'h3C);

        // Read D1 back
        issue(1'b0, 8'hD1, 8'h00, 1'b1, a1);
        idle(4);

        // Back-to-back read D0 then write D0 <= A5 with valid held
        issue(1'b0, 8'hD0, 8'h00, 1'b1, a1);
        issue(1'b1, 8'hD0, 8'hA5, 1'b1, a2);
        check("b2b_spacing", a2 - a1, RL + 1);
        idle(3);
        check("resp_reg0", {24'd0, regs[0]}, 32'hA5);

        // Unmapped read still completes on time
        issue(1'b0, 8'h40, 8'h00, 1'b1, a1);
        idle(4);

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            int r;
            logic [7:0] a;
            r = $urandom_range(0, 9);
            a = (r < 4) ? 8'hD0 : (r < 8) ? 8'hD1 : 8'h40;
            issue(1'($urandom_range(0, 1)), a, 8'($urandom), 1'b1, a1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(5);

        // Interrupts: both raised, lowest first, holdoff blocks re-latch
        raise_set = 2'b11;
        @(posedge CLK);
        #1;
        raise_set = 2'b00;
        repeat (2) @(posedge CLK);
        #1;
        check("irq_both_pending", {31'd0, host_if.irq_pending}, 32'd1);
        check("irq_id_first", {31'd0, host_if.irq_id}, 32'd0);
        irq_ack_pulse();
        check("ack_line0", {30'd0, bus_ack}, 32'd1);
        check("irq_id_second", {31'd0, host_if.irq_id}, 32'd1);
        @(posedge CLK);
        #1;
        check("ack_line0_one_cycle", {30'd0, bus_ack}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        check("no_relatch_line0", {31'd0, host_if.irq_id}, 32'd1);
        check("line1_still_pending", {31'd0, host_if.irq_pending}, 32'd1);
        irq_ack_pulse();
        check("ack_line1", {30'd0, bus_ack}, 32'd2);
        repeat (3) @(posedge CLK);
        #1;
        check("irq_all_clear", {31'd0, host_if.irq_pending}, 32'd0);
        check("ack_idle", {30'd0, bus_ack}, 32'd0);

        // Ack with nothing pending is ignored
        irq_ack_pulse();
        check("spurious_ack_none", {30'd0, bus_ack}, 32'd0);
        @(posedge CLK);
        #1;
        check("spurious_ack_none_2", {30'd0, bus_ack}, 32'd0);
        check("spurious_pending", {31'd0, host_if.irq_pending}, 32'd0);

        idle(5);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
